alu_writeback: RTL and testbench

ALU_WRITEBACK -- requirements
Module: alu_writeback

---
 rtl/alu_pkg.sv | 30 +++
 rtl/sat_counter.sv | 31 +++
 rtl/alu_writeback.sv | 134 +++++++++++++
 tb/tb_alu_writeback.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU function codes and writeback FSM state encoding.
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_NOP = 4'b0000;
  localparam logic [OP_W-1:0] OP_MUL = 4'b0001;
  localparam logic [OP_W-1:0] OP_DIV = 4'b0010;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0011;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0100;
  localparam logic [OP_W-1:0] OP_AND = 4'b0101;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0110;
  localparam logic [OP_W-1:0] OP_SLL = 4'b0111;
  localparam logic [OP_W-1:0] OP_SLR = 4'b1000;
  localparam logic [OP_W-1:0] OP_ROL = 4'b1001;
  localparam logic [OP_W-1:0] OP_ROR = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WR_LO = 2'd1,
    ST_WR_HI = 2'd2,
    ST_EXC   = 2'd3
  } wb_state_e;

  // MUL and DIV produce a second (high) word that lands in HI_REG.
  function automatic logic op_has_hi(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/alu_writeback.sv
// Writeback stage: turns one ALU result into zero, one or two register-file
// writes, or an exception pulse with a saturating fault count.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | nothing to write; accepting results
// ST_WR_LO | writing R to dest; if hi pending, S follows next cycle
// ST_WR_HI | writing S to HI_REG (always after the low write)
// ST_EXC   | faulting result: pulse exc_valid, bump counter, no write
module alu_writeback
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int CTRL_W = 4,
  parameter int HI_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] r_in,
  input  logic [DATA_W-1:0] s_in,
  input  logic              exc_in,
  input  logic [ADDR_W-1:0] dest,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              exc_valid,
  output logic [7:0]        exc_count
);

  wb_state_e         state_q, state_d;
  logic              hi_q, hi_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] r_q, r_d;
  logic [DATA_W-1:0] s_q, s_d;
  logic              transfer;
  logic              is_hi_op;
  logic              is_nop;

  // Only the low write of a two-word result must stall; every other state
  // finishes this cycle and can take a new result for full-rate streaming.
  assign ready_out = !((state_q == ST_WR_LO) && hi_q);
  assign transfer  = valid_in && ready_out;
  assign is_hi_op  = op_has_hi(OP_W'(alu_ctrl));
  assign is_nop    = (alu_ctrl == CTRL_W'(OP_NOP));

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    dest_d  = dest_q;
    r_d     = r_q;
    s_d     = s_q;
    if (transfer) begin
      dest_d = dest;
      r_d    = r_in;
      s_d    = s_in;
      hi_d   = 1'b0;
      if (exc_in) begin
        state_d = ST_EXC;
      end else if (is_hi_op) begin
        state_d = ST_WR_LO;
        hi_d    = 1'b1;
      end else if (is_nop) begin
        state_d = ST_IDLE;
      end else begin
        state_d = ST_WR_LO;
      end
    end else begin
      case (state_q)
        ST_WR_LO: begin
          state_d = hi_q ? ST_WR_HI : ST_IDLE;
          hi_d    = 1'b0;
        end
        ST_WR_HI: state_d = ST_IDLE;
        ST_EXC:   state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    case (state_q)
      ST_WR_LO: begin
        wr_en   = 1'b1;
        wr_addr = dest_q;
        wr_data = r_q;
      end
      ST_WR_HI: begin
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(HI_REG);
        wr_data = s_q;
      end
      default: begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
      end
    endcase
  end

  assign exc_valid = (state_q == ST_EXC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hi_q    <= 1'b0;
      dest_q  <= '0;
      r_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      dest_q  <= dest_d;
      r_q     <= r_d;
      s_q     <= s_d;
    end
  end

  sat_counter #(
    .WIDTH(8)
  ) u_exc_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (exc_valid),
    .count_o(exc_count)
  );

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios plus random
// traffic against a queue-of-pending-actions reference model.
module tb_alu_writeback;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic        ready_out;
  logic [3:0]  alu_ctrl;
  logic [15:0] r_in;
  logic [15:0] s_in;
  logic        exc_in;
  logic [3:0]  dest;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        exc_valid;
  logic [7:0]  exc_count;

  int n_tests = 0;
  int n_fail  = 0;

  alu_writeback #(
    .DATA_W(16), .ADDR_W(4), .CTRL_W(4), .HI_REG(0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .alu_ctrl (alu_ctrl),
    .r_in     (r_in),
    .s_in     (s_in),
    .exc_in   (exc_in),
    .dest     (dest),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .exc_valid(exc_valid),
    .exc_count(exc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each accepted result becomes a list of per-cycle actions.
  typedef struct packed {
    logic        we;
    logic [3:0]  addr;
    logic [15:0] data;
    logic        exc;
  } act_t;

  act_t pend[$];
  int   m_cnt = 0;

  function automatic act_t mk(input logic we, input logic [3:0] a,
                              input logic [15:0] d, input logic e);
    act_t t;
    t.we = we; t.addr = a; t.data = d; t.exc = e;
    return t;
  endfunction

  task automatic step(input logic v, input logic [3:0] c, input logic [15:0] r,
                      input logic [15:0] s, input logic e, input logic [3:0] d,
                      input logic rs);
    logic m_rdy;
    valid_in = v; alu_ctrl = c; r_in = r; s_in = s; exc_in = e; dest = d; rst = rs;
    m_rdy = (pend.size() <= 1);
    @(posedge clk);
    if (rs) begin
      pend.delete();
      m_cnt = 0;
    end else begin
      if (pend.size() > 0) begin
        if (pend[0].exc && m_cnt < 255) m_cnt++;
        void'(pend.pop_front());
      end
      if (v && m_rdy) begin
        if (e) pend.push_back(mk(1'b0, 4'd0, 16'd0, 1'b1));
        else if (c == 4'b0001 || c == 4'b0010) begin
          pend.push_back(mk(1'b1, d, r, 1'b0));
          pend.push_back(mk(1'b1, 4'd0, s, 1'b0));
        end else if (c != 4'b0000) pend.push_back(mk(1'b1, d, r, 1'b0));
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 16'd0, 16'd0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, OP_MUL, 16'hFFFF, 16'hFFFF, 1'b0, 4'd7, 1'b1);
    step(1'b0, 4'd0, 16'd0, 16'd0, 1'b0, 4'd0, 1'b1);
    n_tests++;
    if ({wr_en, wr_addr, wr_data, exc_valid} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%b addr=%h data=%h exc=%b, expected all 0",
               wr_en, wr_addr, wr_data, exc_valid);
    end
    n_tests++;
    if (exc_count !== 8'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d expected 0", exc_count);
    end
    n_tests++;
    if (ready_out !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 1", ready_out);
    end
  endtask

  task automatic test_add();
    step(1'b1, OP_ADD, 16'h1234, 16'h0000, 1'b0, 4'd3, 1'b0);
    n_tests++;
    if ({wr_en, wr_addr, wr_data, ready_out} !== {1'b1, 4'd3, 16'h1234, 1'b1}) begin
      n_fail++;
      $display("FAIL add_write: got en=%b addr=%0d data=%h rdy=%b, expected 1 3 1234 1",
               wr_en, wr_addr, wr_data, ready_out);
    end
    idle();
    n_tests++;
    if ({wr_en, wr_addr, wr_data} !== 21'd0) begin
      n_fail++;
      $display("FAIL add_after: got en=%b addr=%0d data=%h, expected 0 0 0", wr_en, wr_addr, wr_data);
    end
  endtask

  task automatic test_mul();
    step(1'b1, OP_MUL, 16'h0010, 16'h0002, 1'b0, 4'd5, 1'b0);
    n_tests++;
    if ({wr_en, wr_addr, wr_data, ready_out} !== {1'b1, 4'd5, 16'h0010, 1'b0}) begin
      n_fail++;
      $display("FAIL mul_lo: got en=%b addr=%0d data=%h rdy=%b, expected 1 5 0010 0",
               wr_en, wr_addr, wr_data, ready_out);
    end
    idle();
    n_tests++;
    if ({wr_en, wr_addr, wr_data, ready_out} !== {1'b1, 4'd0, 16'h0002, 1'b1}) begin
      n_fail++;
      $display("FAIL mul_hi: got en=%b addr=%0d data=%h rdy=%b, expected 1 0 0002 1",
               wr_en, wr_addr, wr_data, ready_out);
    end
    idle();
    n_tests++;
    if (wr_en !== 1'b0) begin
      n_fail++; $display("FAIL mul_done: got wr_en=%b expected 0", wr_en);
    end
  endtask

  task automatic test_exc();
    step(1'b1, OP_SUB, 16'h8000, 16'h0000, 1'b1, 4'd7, 1'b0);
    n_tests++;
    if ({exc_valid, wr_en, exc_count} !== {1'b1, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL exc_pulse: got exc=%b en=%b cnt=%0d, expected 1 0 0", exc_valid, wr_en, exc_count);
    end
    idle();
    n_tests++;
    if ({exc_valid, wr_en, exc_count} !== {1'b0, 1'b0, 8'd1}) begin
      n_fail++;
      $display("FAIL exc_after: got exc=%b en=%b cnt=%0d, expected 0 0 1", exc_valid, wr_en, exc_count);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, OP_ADD, 16'hA000 + 16'(i), 16'h0, 1'b0, 4'(i), 1'b0);
      n_tests++;
      if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'(i), 16'hA000 + 16'(i)}) begin
        n_fail++;
        $display("FAIL b2b_%0d: got en=%b addr=%0d data=%h, expected 1 %0d %h",
                 i, wr_en, wr_addr, wr_data, i, 16'hA000 + 16'(i));
      end
    end
    idle();
    n_tests++;
    if (wr_en !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end: got wr_en=%b expected 0", wr_en);
    end
  endtask

  task automatic test_div_dest0();
    step(1'b1, OP_DIV, 16'hAAAA, 16'h5555, 1'b0, 4'd0, 1'b0);
    n_tests++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'd0, 16'hAAAA}) begin
      n_fail++;
      $display("FAIL div_lo: got en=%b addr=%0d data=%h, expected 1 0 aaaa", wr_en, wr_addr, wr_data);
    end
    idle();
    n_tests++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'd0, 16'h5555}) begin
      n_fail++;
      $display("FAIL div_hi: got en=%b addr=%0d data=%h, expected 1 0 5555", wr_en, wr_addr, wr_data);
    end
    idle();
  endtask

  task automatic test_rst_mid_mul();
    step(1'b1, OP_MUL, 16'h1111, 16'h2222, 1'b0, 4'd9, 1'b0);
    step(1'b0, 4'd0, 16'd0, 16'd0, 1'b0, 4'd0, 1'b1);
    n_tests++;
    if ({wr_en, wr_addr, wr_data, exc_valid, exc_count, ready_out} !== {30'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_mid_mul: got en=%b addr=%0d data=%h exc=%b cnt=%0d rdy=%b, expected zeros rdy=1",
               wr_en, wr_addr, wr_data, exc_valid, exc_count, ready_out);
    end
    idle();
    n_tests++;
    if (wr_en !== 1'b0) begin
      n_fail++; $display("FAIL rst_no_hi: got wr_en=%b expected 0", wr_en);
    end
  endtask

  task automatic test_nop();
    step(1'b1, OP_NOP, 16'hBEEF, 16'hCAFE, 1'b0, 4'd4, 1'b0);
    n_tests++;
    if ({wr_en, exc_valid, ready_out} !== 3'b001) begin
      n_fail++;
      $display("FAIL nop: got en=%b exc=%b rdy=%b, expected 0 0 1", wr_en, exc_valid, ready_out);
    end
    idle();
    n_tests++;
    if ({wr_en, exc_valid} !== 2'b00) begin
      n_fail++; $display("FAIL nop_after: got en=%b exc=%b, expected 0 0", wr_en, exc_valid);
    end
  endtask

  task automatic test_saturation();
    step(1'b0, 4'd0, 16'd0, 16'd0, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      step(1'b1, OP_SUB, 16'h0, 16'h0, 1'b1, 4'd1, 1'b0);
      if (i == 254) begin
        n_tests++;
        if (exc_count !== 8'd254) begin
          n_fail++; $display("FAIL sat_mid: got %0d expected 254", exc_count);
        end
      end
    end
    idle();
    n_tests++;
    if (exc_count !== 8'd255) begin
      n_fail++; $display("FAIL sat_end: got %0d expected 255", exc_count);
    end
  endtask

  task automatic test_random();
    act_t e;
    step(1'b0, 4'd0, 16'd0, 16'd0, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 16'($urandom),
           16'($urandom), ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 63) == 0));
      e = (pend.size() > 0) ? pend[0] : mk(1'b0, 4'd0, 16'd0, 1'b0);
      n_tests++;
      if ({wr_en, wr_addr, wr_data, exc_valid, exc_count, ready_out} !==
          {e.we, e.addr, e.data, e.exc, 8'(m_cnt), (pend.size() <= 1)}) begin
        n_fail++;
        $display("FAIL random_%0d: got en=%b addr=%0d data=%h exc=%b cnt=%0d rdy=%b, expected en=%b addr=%0d data=%h exc=%b cnt=%0d rdy=%b",
                 i, wr_en, wr_addr, wr_data, exc_valid, exc_count, ready_out,
                 e.we, e.addr, e.data, e.exc, m_cnt, (pend.size() <= 1));
      end
    end
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; alu_ctrl = '0; r_in = '0; s_in = '0;
    exc_in = 1'b0; dest = '0;
    test_reset();
    test_add();
    test_mul();
    test_exc();
    test_back_to_back();
    test_div_dest0();
    test_rst_mid_mul();
    test_nop();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
